// File: rtl/es_ctrl.sv
// I/O sequencer for the 4-port I/O block: accepts one CPU IN/OUT request at a time,
// runs the valid/ack handshake with the addressed peripheral, and drives the block's selects/enables.
module es_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_req,
  input  logic       io_wr,
  input  logic [1:0] io_port,
  input  logic       io_src,
  input  logic [3:0] in_valid,
  input  logic [3:0] out_ack,
  output logic       io_busy,
  output logic       io_done,
  output logic       io_timeout,
  output logic [1:0] id_in,
  output logic [1:0] id_out,
  output logic       sec,
  output logic       sece,
  output logic       rwe1,
  output logic       rwe2,
  output logic       rwe3,
  output logic       rwe4,
  output logic [3:0] in_ack,
  output logic [3:0] out_valid
);

  // state     | meaning
  // S_IDLE    | no request in flight; io_req sampled here
  // S_WR_WAIT | OUT pending, waiting for out_valid[p] to drop
  // S_WRITE   | load output register p, pulse io_done
  // S_RD_WAIT | IN pending, waiting for in_valid[p]
  // S_READ    | CPU takes data_in, pulse io_done and in_ack[p]
  // S_ERR     | peripheral never answered, pulse io_timeout
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_WAIT,
    S_WRITE,
    S_RD_WAIT,
    S_READ,
    S_ERR
  } state_t;

  localparam bit            TMO_EN   = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    port_q, port_d;
  logic          src_q, src_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    out_valid_q, out_valid_d;
  logic [3:0]    port_oh;
  logic [3:0]    rwe_vec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      port_q      <= 2'd0;
      src_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign port_oh = 4'b0001 << port_q;

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    // acks on bits that are already clear fall out of this mask naturally
    out_valid_d = out_valid_q & ~out_ack;
    io_busy     = (state_q != S_IDLE);
    io_done     = 1'b0;
    io_timeout  = 1'b0;
    sece        = 1'b0;
    rwe_vec     = 4'd0;
    in_ack      = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (io_req) begin
          port_d  = io_port;
          src_d   = io_src;
          cnt_d   = '0;
          state_d = io_wr ? S_WR_WAIT : S_RD_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (!out_valid_q[port_q]) begin
          state_d = S_WRITE;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        sece        = 1'b1;
        rwe_vec     = port_oh;
        io_done     = 1'b1;
        out_valid_d = out_valid_d | port_oh;
        state_d     = S_IDLE;
      end
      S_RD_WAIT: begin
        if (in_valid[port_q]) begin
          state_d = S_READ;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READ: begin
        io_done = 1'b1;
        in_ack  = port_oh;
        state_d = S_IDLE;
      end
      S_ERR: begin
        io_timeout = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // both mux selects track the latched port and hold it through IDLE
  assign id_in     = port_q;
  assign id_out    = port_q;
  assign sec       = src_q;
  assign rwe1      = rwe_vec[0];
  assign rwe2      = rwe_vec[1];
  assign rwe3      = rwe_vec[2];
  assign rwe4      = rwe_vec[3];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_es_ctrl.sv
// Bench for es_ctrl: table of requests with hand-derived latencies, scoreboard of expected
// completions checked by a negedge monitor, plus reset, multi-ack and TIMEOUT=0 sequences.
module tb_es_ctrl;

  localparam int T = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       io_req, io_wr, io_src;
  logic [1:0] io_port;
  logic [3:0] in_valid, out_ack;
  logic       io_busy, io_done, io_timeout, sec, sece, rwe1, rwe2, rwe3, rwe4;
  logic [1:0] id_in, id_out;
  logic [3:0] in_ack, out_valid, rwe_v;

  logic       z_req, z_wr, z_src;
  logic [1:0] z_port;
  logic [3:0] z_in_valid, z_out_ack;
  logic       z_busy, z_done, z_timeout, z_sec, z_sece, z_rwe1, z_rwe2, z_rwe3, z_rwe4;
  logic [1:0] z_id_in, z_id_out;
  logic [3:0] z_in_ack, z_out_valid;

  assign rwe_v = {rwe4, rwe3, rwe2, rwe1};

  es_ctrl #(.TIMEOUT(T), .CW(8)) dut (
    .clk(clk), .reset(reset), .io_req(io_req), .io_wr(io_wr), .io_port(io_port),
    .io_src(io_src), .in_valid(in_valid), .out_ack(out_ack), .io_busy(io_busy),
    .io_done(io_done), .io_timeout(io_timeout), .id_in(id_in), .id_out(id_out),
    .sec(sec), .sece(sece), .rwe1(rwe1), .rwe2(rwe2), .rwe3(rwe3), .rwe4(rwe4),
    .in_ack(in_ack), .out_valid(out_valid)
  );

  es_ctrl #(.TIMEOUT(0), .CW(8)) dut_z (
    .clk(clk), .reset(reset), .io_req(z_req), .io_wr(z_wr), .io_port(z_port),
    .io_src(z_src), .in_valid(z_in_valid), .out_ack(z_out_ack), .io_busy(z_busy),
    .io_done(z_done), .io_timeout(z_timeout), .id_in(z_id_in), .id_out(z_id_out),
    .sec(z_sec), .sece(z_sece), .rwe1(z_rwe1), .rwe2(z_rwe2), .rwe3(z_rwe3), .rwe4(z_rwe4),
    .in_ack(z_in_ack), .out_valid(z_out_valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // rdy/ack: negedge index after the request at which the peripheral becomes ready (-1 never)
  typedef struct {
    bit         wr;
    logic [1:0] port;
    bit         src;
    int         rdy;
    int         ack;
    bit         exp_tmo;
    int         exp_lat;
  } vec_t;

  typedef struct {
    bit         tmo;
    int         cyc;
    logic [3:0] rwe;
    logic [3:0] inack;
    logic [1:0] id;
    bit         sece;
    bit         sec;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] ov_model;
  bit         mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (io_done || io_timeout) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'({io_done, io_timeout}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("timeout_flag", 32'(io_timeout), 32'(mon_e.tmo));
          chk("done_flag", 32'(io_done), 32'(!mon_e.tmo));
          chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rwe", 32'(rwe_v), 32'(mon_e.rwe));
          chk("in_ack", 32'(in_ack), 32'(mon_e.inack));
          chk("id_in", 32'(id_in), 32'(mon_e.id));
          chk("id_out", 32'(id_out), 32'(mon_e.id));
          chk("sece", 32'(sece), 32'(mon_e.sece));
          chk("sec", 32'(sec), 32'(mon_e.sec));
        end
      end else begin
        chk("strobes_off", 32'({sece, rwe_v, in_ack}), 32'd0);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   k;
    int   j;
    bit   seen;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(ov_model));
    chk("idle_busy", 32'(io_busy), 32'd0);
    io_req  = 1'b1;
    io_wr   = v.wr;
    io_port = v.port;
    io_src  = v.src;
    if (!v.wr && v.rdy == 0) in_valid[v.port] = 1'b1;
    k       = cyc + 1;
    e.tmo   = v.exp_tmo;
    e.cyc   = k + v.exp_lat;
    e.rwe   = (v.wr && !v.exp_tmo) ? (4'b0001 << v.port) : 4'd0;
    e.inack = (!v.wr && !v.exp_tmo) ? (4'b0001 << v.port) : 4'd0;
    e.id    = v.port;
    e.sece  = v.wr && !v.exp_tmo;
    e.sec   = v.src;
    sb.push_back(e);
    seen = 1'b0;
    j    = 0;
    while (!seen && j < 400) begin
      @(negedge clk);
      j++;
      out_ack = 4'd0;
      chk("busy", 32'(io_busy), 32'd1);
      if (io_done || io_timeout) begin
        seen = 1'b1;
      end else begin
        if (!v.wr && v.rdy == j) in_valid[v.port] = 1'b1;
        if (v.wr && v.ack == j) out_ack[v.port] = 1'b1;
      end
    end
    if (!seen) begin
      chk("completion_wait", 32'd0, 32'd1);
      sb.delete();
    end
    io_req   = 1'b0;
    in_valid = 4'd0;
    out_ack  = 4'd0;
    if (v.wr && !v.exp_tmo) ov_model[v.port] = 1'b1;
  endtask

  vec_t vecs[11];
  int   zbusy_drop;
  int   zpulse;

  initial begin
    reset = 1'b0; io_req = 1'b0; io_wr = 1'b0; io_port = 2'd0; io_src = 1'b0;
    in_valid = 4'd0; out_ack = 4'd0;
    z_req = 1'b0; z_wr = 1'b0; z_port = 2'd0; z_src = 1'b0; z_in_valid = 4'd0; z_out_ack = 4'd0;
    ov_model = 4'd0;

    //           wr    port  src   rdy   ack  tmo   lat
    vecs[0]  = '{1'b1, 2'd2, 1'b1, -1,  -1,  1'b0, 1};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, -1,  -1,  1'b1, T};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, -1,   3,  1'b0, 4};
    vecs[3]  = '{1'b0, 2'd1, 1'b0,  5,  -1,  1'b0, 5};
    vecs[4]  = '{1'b1, 2'd0, 1'b1, -1,  -1,  1'b0, 1};
    vecs[5]  = '{1'b1, 2'd3, 1'b0, -1,  -1,  1'b0, 1};
    vecs[6]  = '{1'b0, 2'd0, 1'b0,  0,  -1,  1'b0, 1};
    vecs[7]  = '{1'b0, 2'd3, 1'b0,  T,  -1,  1'b0, T};
    vecs[8]  = '{1'b0, 2'd2, 1'b0,  T+1, -1, 1'b1, T};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, -1,   1,  1'b0, 2};
    vecs[10] = '{1'b0, 2'd3, 1'b1,  1,  -1,  1'b0, 1};

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 32'({io_busy, io_done, io_timeout, id_in, id_out, sec, sece, rwe_v, in_ack, out_valid}), 32'd0);
    chk("reset_outputs_z", 32'({z_busy, z_done, z_timeout, z_id_in, z_id_out, z_sec, z_sece, z_in_ack, z_out_valid}), 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // acks on every bit at once; bit 1 is clear and must stay clear
    @(negedge clk);
    chk("ov_before_ack_all", 32'(out_valid), 32'(ov_model));
    out_ack = 4'hF;
    @(negedge clk);
    out_ack  = 4'd0;
    ov_model = 4'd0;
    chk("ack_all", 32'(out_valid), 32'(ov_model));

    run_vec('{1'b1, 2'd1, 1'b0, -1, -1, 1'b0, 1});

    // reset while an IN request sits in RD_WAIT
    @(negedge clk);
    chk("ov_before_reset", 32'(out_valid), 32'(ov_model));
    io_req = 1'b1; io_wr = 1'b0; io_port = 2'd1;
    repeat (3) @(negedge clk);
    chk("rd_wait_busy", 32'(io_busy), 32'd1);
    reset  = 1'b0;
    io_req = 1'b0;
    @(negedge clk);
    chk("reset_mid_busy", 32'(io_busy), 32'd0);
    chk("reset_mid_done", 32'({io_done, io_timeout}), 32'd0);
    chk("reset_mid_ov", 32'(out_valid), 32'd0);
    reset    = 1'b1;
    ov_model = 4'd0;

    // TIMEOUT=0 build: an IN that never becomes ready must stall indefinitely
    @(negedge clk);
    z_req = 1'b1; z_wr = 1'b0; z_port = 2'd3;
    zbusy_drop = 0;
    zpulse     = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!z_busy) zbusy_drop++;
      if (z_timeout || z_done) zpulse++;
    end
    chk("z_busy_held", 32'(zbusy_drop), 32'd0);
    chk("z_no_pulse", 32'(zpulse), 32'd0);
    z_in_valid[3] = 1'b1;
    @(negedge clk);
    chk("z_done", 32'(z_done), 32'd1);
    chk("z_in_ack", 32'(z_in_ack), 32'b1000);
    z_req = 1'b0; z_in_valid = 4'd0;

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
